// File: rtl/mrr_pathway_output_arbiter_if.sv
// Stream bundle between the decode pathways, the arbiter and the host-side AXI-stream.
// master = arbiter side, slave = pathway sources plus host sink.
interface mrr_pathway_output_arbiter_if #(
    parameter int NUM_PATHWAYS = 4,
    parameter int DATA_WIDTH   = 32
);
    logic [NUM_PATHWAYS*DATA_WIDTH-1:0] i_tdata;
    logic [NUM_PATHWAYS-1:0]            i_tvalid;
    logic [NUM_PATHWAYS-1:0]            i_tlast;
    logic [NUM_PATHWAYS-1:0]            i_tready;
    logic [DATA_WIDTH-1:0]              o_tdata;
    logic                               o_tvalid;
    logic                               o_tlast;
    logic                               o_tready;

    modport master (
        input  i_tdata, i_tvalid, i_tlast, o_tready,
        output i_tready, o_tdata, o_tvalid, o_tlast
    );

    modport slave (
        output i_tdata, i_tvalid, i_tlast, o_tready,
        input  i_tready, o_tdata, o_tvalid, o_tlast
    );
endinterface

// File: rtl/mrr_pathway_output_arbiter.sv
// Packet-locked round-robin merge of per-pathway streams into one host stream,
// with optional header word, stall watchdog/abort, and single-owner TX enable arbitration.
module mrr_pathway_output_arbiter #(
    parameter int NUM_PATHWAYS   = 4,
    parameter int PATH_IDX_WIDTH = 2,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hdr_enable,
    input  logic [15:0]               timeout_len,
    mrr_pathway_output_arbiter_if.master bus,
    input  logic [NUM_PATHWAYS-1:0]   tx_en_in,
    output logic                      tx_en_out,
    output logic [PATH_IDX_WIDTH-1:0] tx_owner,
    output logic [15:0]               tx_collision_cnt,
    output logic [15:0]               abort_cnt
);
    typedef enum logic [2:0] {IDLE, HEADER, DATA, ABORT, FLUSH} state_t;

    state_t                    state_reg;
    logic [PATH_IDX_WIDTH-1:0] grant_reg;
    logic [PATH_IDX_WIDTH-1:0] last_grant_reg;
    logic [15:0]               seq_reg;
    logic [15:0]               wd_cnt_reg;
    logic [15:0]               abort_cnt_reg;
    logic                      tx_en_out_reg;
    logic [PATH_IDX_WIDTH-1:0] tx_owner_reg;
    logic [15:0]               tx_coll_cnt_reg;

    logic [DATA_WIDTH-1:0]     path_data [NUM_PATHWAYS];
    logic                      rr_found;
    logic [PATH_IDX_WIDTH-1:0] rr_pick;
    logic [PATH_IDX_WIDTH-1:0] rr_cand;
    int                        rr_idx;
    logic [PATH_IDX_WIDTH-1:0] tx_pick;
    logic [NUM_PATHWAYS-1:0]   tx_other;
    logic                      data_hs;
    logic                      flush_hs;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PATHWAYS; gi++) begin : g_slice
            assign path_data[gi] = bus.i_tdata[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
        end
    endgenerate

    // Search starts just after the last finished pathway so it drops to lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_reg;
        rr_idx   = 0;
        rr_cand  = '0;
        for (int off = 1; off <= NUM_PATHWAYS; off++) begin
            rr_idx  = (int'(last_grant_reg) + off) % NUM_PATHWAYS;
            rr_cand = PATH_IDX_WIDTH'(rr_idx);
            if (!rr_found && bus.i_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_comb begin
        tx_pick = '0;
        for (int k = NUM_PATHWAYS - 1; k >= 0; k--) begin
            if (tx_en_in[k]) tx_pick = PATH_IDX_WIDTH'(k);
        end
    end

    assign tx_other = tx_en_in & ~(NUM_PATHWAYS'(1) << tx_owner_reg);
    assign data_hs  = bus.i_tvalid[grant_reg] & bus.o_tready;
    assign flush_hs = bus.i_tvalid[grant_reg] & bus.i_tlast[grant_reg];

    // Output mux decodes the registered state; DATA is a pure pass-through of the granted pathway.
    always_comb begin
        bus.o_tdata  = '0;
        bus.o_tvalid = 1'b0;
        bus.o_tlast  = 1'b0;
        bus.i_tready = '0;
        case (state_reg)
            HEADER: begin
                bus.o_tvalid = 1'b1;
                bus.o_tdata  = DATA_WIDTH'({8'hA5, 8'(grant_reg), seq_reg});
            end
            DATA: begin
                bus.o_tdata             = path_data[grant_reg];
                bus.o_tvalid            = bus.i_tvalid[grant_reg];
                bus.o_tlast             = bus.i_tlast[grant_reg];
                bus.i_tready[grant_reg] = bus.o_tready;
            end
            ABORT: begin
                bus.o_tvalid = 1'b1;
                bus.o_tlast  = 1'b1;
                bus.o_tdata  = DATA_WIDTH'({16'hDEAD, 16'(grant_reg)});
            end
            FLUSH: bus.i_tready[grant_reg] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= PATH_IDX_WIDTH'(NUM_PATHWAYS - 1);
            seq_reg        <= '0;
            wd_cnt_reg     <= '0;
            abort_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wd_cnt_reg <= '0;
                    if (rr_found) begin
                        grant_reg <= rr_pick;
                        state_reg <= hdr_enable ? HEADER : DATA;
                    end
                end
                HEADER: if (bus.o_tready) state_reg <= DATA;
                DATA: begin
                    // A word moving this cycle wins over an expiring watchdog.
                    if (data_hs) begin
                        wd_cnt_reg <= '0;
                        if (bus.i_tlast[grant_reg]) begin
                            last_grant_reg <= grant_reg;
                            seq_reg        <= seq_reg + 16'd1;
                            state_reg      <= IDLE;
                        end
                    end else if (timeout_len != 16'd0 && wd_cnt_reg == timeout_len) begin
                        state_reg <= ABORT;
                    end else if (!bus.i_tvalid[grant_reg]) begin
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
                    end
                end
                ABORT: begin
                    if (bus.o_tready) begin
                        state_reg <= FLUSH;
                        if (abort_cnt_reg != 16'hFFFF) abort_cnt_reg <= abort_cnt_reg + 16'd1;
                    end
                end
                FLUSH: begin
                    if (flush_hs) begin
                        last_grant_reg <= grant_reg;
                        seq_reg        <= seq_reg + 16'd1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Release cycle never grants, leaving a one-cycle guard gap on tx_en_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_en_out_reg   <= 1'b0;
            tx_owner_reg    <= '0;
            tx_coll_cnt_reg <= '0;
        end else if (tx_en_out_reg) begin
            if (!tx_en_in[tx_owner_reg]) tx_en_out_reg <= 1'b0;
            if (|tx_other && tx_coll_cnt_reg != 16'hFFFF)
                tx_coll_cnt_reg <= tx_coll_cnt_reg + 16'd1;
        end else if (|tx_en_in) begin
            tx_owner_reg  <= tx_pick;
            tx_en_out_reg <= 1'b1;
        end
    end

    assign tx_en_out        = tx_en_out_reg;
    assign tx_owner         = tx_owner_reg;
    assign tx_collision_cnt = tx_coll_cnt_reg;
    assign abort_cnt        = abort_cnt_reg;
endmodule

// File: tb/tb_mrr_pathway_output_arbiter.sv
// Scoreboard bench: per-pathway queued sources feed the arbiter, expected host words are
// queued as stimulus is issued, and a negedge monitor pops/compares on every output handshake.
module tb_mrr_pathway_output_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          delay;
    } src_word_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_enable = 1'b0;
    logic [15:0] timeout_len = 16'd0;
    logic [NP-1:0] tx_en_in = '0;
    logic        tx_en_out;
    logic [1:0]  tx_owner;
    logic [15:0] tx_collision_cnt;
    logic [15:0] abort_cnt;

    int tests = 0;
    int fails = 0;

    src_word_t src_q [NP][$];
    exp_word_t exp_q [$];

    mrr_pathway_output_arbiter_if #(.NUM_PATHWAYS(NP), .DATA_WIDTH(DW)) bus ();

    mrr_pathway_output_arbiter #(
        .NUM_PATHWAYS(NP), .PATH_IDX_WIDTH(2), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst_n), .hdr_enable(hdr_enable), .timeout_len(timeout_len),
        .bus(bus), .tx_en_in(tx_en_in), .tx_en_out(tx_en_out), .tx_owner(tx_owner),
        .tx_collision_cnt(tx_collision_cnt), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_src(input int k, input logic [31:0] d, input logic l, input int dly);
        src_word_t w;
        w.data = d; w.last = l; w.delay = dly;
        src_q[k].push_back(w);
    endtask

    task automatic expect_out(input logic [31:0] d, input logic l);
        exp_word_t e;
        e.data = d; e.last = l;
        exp_q.push_back(e);
    endtask

    function automatic bit src_busy();
        for (int k = 0; k < NP; k++) if (src_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || src_busy() || bus.o_tvalid) && n < 2000) begin
            step();
            n++;
        end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL %s drain: %0d expected words left, required 0", name, exp_q.size());
            exp_q.delete();
        end
        step(); step();
    endtask

    // Pathway sources: hold each word until handshaken; 'delay' keeps tvalid low first.
    initial begin
        bit hs [NP];
        src_word_t w;
        bus.i_tvalid = '0;
        bus.i_tlast  = '0;
        bus.i_tdata  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NP; k++) hs[k] = bus.i_tvalid[k] & bus.i_tready[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < NP; k++) begin
                if (hs[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                bus.i_tvalid[k] = 1'b0;
                bus.i_tlast[k]  = 1'b0;
                if (src_q[k].size() != 0) begin
                    w = src_q[k][0];
                    if (w.delay > 0) begin
                        w.delay--;
                        src_q[k][0] = w;
                    end else begin
                        bus.i_tvalid[k]         = 1'b1;
                        bus.i_tlast[k]          = w.last;
                        bus.i_tdata[32*k +: 32] = w.data;
                    end
                end
            end
        end
    end

    // Monitor: one line per host-side transaction.
    initial begin
        exp_word_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_tvalid && bus.o_tready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream: got unexpected word %h last=%0b, required none", bus.o_tdata, bus.o_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_tdata !== e.data || bus.o_tlast !== e.last) begin
                        fails++;
                        $display("FAIL stream: got %h last=%0b expected %h last=%0b",
                                 bus.o_tdata, bus.o_tlast, e.data, e.last);
                    end else begin
                        $display("[TB] out %h last=%0b ok", bus.o_tdata, bus.o_tlast);
                    end
                end
            end
        end
    end

    logic [3:0]  tx_in_tab  [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic        tx_out_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  tx_own_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [15:0] tx_cnt_tab [8] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};

    initial begin
        int n;
        bus.o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst o_tvalid", 32'(bus.o_tvalid), 32'd0);
        check("rst o_tdata", bus.o_tdata, 32'd0);
        check("rst i_tready", 32'(bus.i_tready), 32'd0);
        check("rst tx_en_out", 32'(tx_en_out), 32'd0);
        check("rst abort_cnt", 32'(abort_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Pathway 2 alone, header on, seq 0.
        hdr_enable = 1'b1;
        expect_out(32'hA502_0000, 1'b0);
        expect_out(32'h2000_0001, 1'b0);
        expect_out(32'h2000_0002, 1'b0);
        expect_out(32'h2000_0003, 1'b1);
        push_src(2, 32'h2000_0001, 1'b0, 0);
        push_src(2, 32'h2000_0002, 1'b0, 0);
        push_src(2, 32'h2000_0003, 1'b1, 0);
        wait_drain("single");

        // Pathways 0 and 1 contending, no header: whole packets alternate 0,1,0,1.
        hdr_enable = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                push_src(k, 32'h0A00_0000 | (k << 16) | (p << 4) | 1, 1'b0, 0);
                push_src(k, 32'h0A00_0000 | (k << 16) | (p << 4) | 2, 1'b1, 0);
                expect_out(32'h0A00_0000 | (k << 16) | (p << 4) | 1, 1'b0);
                expect_out(32'h0A00_0000 | (k << 16) | (p << 4) | 2, 1'b1);
            end
        end
        wait_drain("round_robin");

        // Watchdog: pathway 1 stalls 10 cycles after its first word.
        timeout_len = 16'd5;
        expect_out(32'h1B00_0001, 1'b0);
        expect_out(32'h0000_DEAD_0001 & 32'hFFFF_FFFF, 1'b1);
        push_src(1, 32'h1B00_0001, 1'b0, 0);
        push_src(1, 32'h1B00_0002, 1'b0, 10);
        push_src(1, 32'h1B00_0003, 1'b1, 0);
        wait_drain("abort");
        check("abort_cnt after abort", 32'(abort_cnt), 32'd1);

        // Downstream backpressure for 50 cycles must not trip the watchdog.
        hdr_enable = 1'b1;
        expect_out(32'hA503_0006, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            push_src(3, 32'h3C00_0000 | i, (i == 4), 0);
            expect_out(32'h3C00_0000 | i, (i == 4));
        end
        n = 0;
        while (exp_q.size() > 3 && n < 200) begin
            step();
            n++;
        end
        check("backpressure start", 32'(exp_q.size()), 32'd3);
        bus.o_tready = 1'b0;
        repeat (50) step();
        bus.o_tready = 1'b1;
        wait_drain("backpressure");
        check("abort_cnt after backpressure", 32'(abort_cnt), 32'd1);

        // TX ownership table, driven after one edge and checked mid-cycle.
        for (int c = 0; c < 8; c++) begin
            step();
            tx_en_in = tx_in_tab[c];
            @(negedge clk);
            check($sformatf("tx_en_out c%0d", c), 32'(tx_en_out), 32'(tx_out_tab[c]));
            check($sformatf("tx_owner c%0d", c), 32'(tx_owner), 32'(tx_own_tab[c]));
            check($sformatf("tx_collision_cnt c%0d", c), 32'(tx_collision_cnt), 32'(tx_cnt_tab[c]));
        end

        // Make pathway 0 the last grant, then reset mid-packet on pathway 1.
        step();
        hdr_enable = 1'b0;
        tx_en_in   = 4'b0001;
        expect_out(32'h0C00_0001, 1'b1);
        push_src(0, 32'h0C00_0001, 1'b1, 0);
        wait_drain("pre_reset");
        bus.o_tready = 1'b0;
        push_src(1, 32'h1D00_0001, 1'b0, 0);
        push_src(1, 32'h1D00_0002, 1'b1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tvalid && n < 50);
        check("mid-DATA o_tvalid", 32'(bus.o_tvalid), 32'd1);
        check("pre-reset tx_en_out", 32'(tx_en_out), 32'd1);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < NP; k++) src_q[k].delete();
        tx_en_in = '0;
        #1;
        check("async rst o_tvalid", 32'(bus.o_tvalid), 32'd0);
        check("async rst o_tdata", bus.o_tdata, 32'd0);
        check("async rst o_tlast", 32'(bus.o_tlast), 32'd0);
        check("async rst tx_en_out", 32'(tx_en_out), 32'd0);
        check("async rst abort_cnt", 32'(abort_cnt), 32'd0);
        check("async rst tx_collision_cnt", 32'(tx_collision_cnt), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        bus.o_tready = 1'b1;
        hdr_enable = 1'b1;
        expect_out(32'hA500_0000, 1'b0);
        expect_out(32'h0E00_0001, 1'b1);
        expect_out(32'hA501_0001, 1'b0);
        expect_out(32'h1E00_0001, 1'b1);
        push_src(0, 32'h0E00_0001, 1'b1, 0);
        push_src(1, 32'h1E00_0001, 1'b1, 0);
        wait_drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
